// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline. It handles load-use hazards, taken branches
// resolved in MEM and data-memory wait states, and keeps saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_ifid_rs,
  input  logic [4:0]       i_ifid_rt,
  input  logic             i_ifid_uses_rt,
  input  logic             i_idex_MemRead,
  input  logic [4:0]       i_idex_rt,
  input  logic             i_exmem_Branch,
  input  logic             i_exmem_Zero,
  input  logic             i_exmem_mem_access,
  input  logic             i_mem_ready,
  output logic             o_pc_write,
  output logic             o_ifid_write,
  output logic             o_pipe_write,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic             o_exmem_flush,
  output logic             o_pc_src,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_stall_count,
  output logic [CNT_W-1:0] o_flush_count,
  output logic [1:0]       o_state
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0]    TO_VAL  = WW'(MEM_TIMEOUT);
  localparam logic [WW-1:0]    WAIT_1  = WW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  // Handshake-free block: every output is a level qualified by the current cycle only;
  // the datapath samples the enables and flushes at the same rising edge as this block.

  state_t          r_state;
  logic [WW-1:0]   r_wait_cnt;
  logic            r_mem_timeout;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;

  state_t        w_next_state;
  logic [WW-1:0] w_next_wait;
  logic          w_set_timeout;
  logic          w_br_event;
  logic          w_mem_hold;
  logic          w_br_take;
  logic          w_lu;

  assign w_mem_hold = i_exmem_mem_access & ~i_mem_ready;
  assign w_br_take  = i_exmem_Branch & i_exmem_Zero;
  assign w_lu       = i_idex_MemRead & (i_idex_rt != 5'd0) &
                      ((i_idex_rt == i_ifid_rs) | (i_ifid_uses_rt & (i_idex_rt == i_ifid_rt)));

  always_comb begin
    o_pc_write    = 1'b1;
    o_ifid_write  = 1'b1;
    o_pipe_write  = 1'b1;
    o_ifid_flush  = 1'b0;
    o_idex_flush  = 1'b0;
    o_exmem_flush = 1'b0;
    o_pc_src      = 1'b0;
    w_next_state  = ST_RUN;
    w_next_wait   = '0;
    w_set_timeout = 1'b0;
    w_br_event    = 1'b0;
    if (i_rst) begin
      o_pc_write    = 1'b0;
      o_ifid_write  = 1'b0;
      o_pipe_write  = 1'b0;
      o_ifid_flush  = 1'b1;
      o_idex_flush  = 1'b1;
      o_exmem_flush = 1'b1;
    end else begin
      case (r_state)
        ST_RUN, ST_LU_STALL: begin
          if (w_mem_hold) begin
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_pipe_write = 1'b0;
            w_next_state = ST_MEM_WAIT;
            w_next_wait  = WAIT_1;
          end else if (w_br_take) begin
            o_pc_src      = 1'b1;
            o_ifid_flush  = 1'b1;
            o_idex_flush  = 1'b1;
            o_exmem_flush = 1'b1;
            w_br_event    = 1'b1;
          end else if (w_lu && (r_state == ST_RUN)) begin
            // The bubble inserted here resolves the hazard, so LU_STALL ignores lu.
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_idex_flush = 1'b1;
            w_next_state = ST_LU_STALL;
          end
        end
        ST_MEM_WAIT: begin
          if (!i_mem_ready && (r_wait_cnt < TO_VAL)) begin
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_pipe_write = 1'b0;
            w_next_state = ST_MEM_WAIT;
            w_next_wait  = r_wait_cnt + WAIT_1;
          end else if (!i_mem_ready) begin
            w_set_timeout = 1'b1;
          end
        end
        default: w_next_state = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait;
      if (w_set_timeout) begin
        r_mem_timeout <= 1'b1;
      end
      if (!o_pc_write && (r_stall_count != CNT_MAX)) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
      if (w_br_event && (r_flush_count != CNT_MAX)) begin
        r_flush_count <= r_flush_count + 1'b1;
      end
    end
  end

  assign o_mem_timeout = r_mem_timeout;
  assign o_stall_count = r_stall_count;
  assign o_flush_count = r_flush_count;
  assign o_state       = r_state;

endmodule
